// File: rtl/lfsr_pkg.sv
// Shared definitions for the LFSR match timer.
// State encoding, LFSR width, default match pattern and a masked half-compare helper.
package lfsr_pkg;

    localparam int LFSR_W = 32;
    localparam logic [31:0] MATCH_PATTERN = 32'h81234567;
    localparam logic [15:0] MATCH_PATTERN_PRESCALE = 16'h8123;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        RUN   = 2'd2
    } state_e;

    // Masked 16-bit equality: a 1 in k makes that bit a don't-care.
    function automatic logic half_eq(
        input logic [15:0] v,
        input logic [15:0] m,
        input logic [15:0] k
    );
        return ((v ^ m) & ~k) == 16'h0000;
    endfunction

endpackage

// File: rtl/lfsr_match_cmp.sv
// Two-stage split comparator: stage 1 compares 16-bit halves, stage 2 forms the hit.
// Optional don't-care mask when LFSR_MATCH_MASK_EN is defined.
module lfsr_match_cmp
    import lfsr_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic [LFSR_W-1:0] lfsr_i,
    input  logic [LFSR_W-1:0] match_i,
`ifdef LFSR_MATCH_MASK_EN
    input  logic [LFSR_W-1:0] mask_i,
`endif
    input  logic              run_i,
    input  logic              flush_i,
    output logic              hit_o,
    output logic              hit_set_o
);

    logic [15:0] mask_hi, mask_lo;
    logic        eq_hi_d, eq_lo_d, v1_d, hit_d;
    logic        eq_hi_q, eq_lo_q, v1_q, hit_q;

`ifdef LFSR_MATCH_MASK_EN
    assign mask_hi = mask_i[31:16];
    assign mask_lo = mask_i[15:0];
`else
    assign mask_hi = 16'h0000;
    assign mask_lo = 16'h0000;
`endif

    assign eq_hi_d = half_eq(lfsr_i[31:16], match_i[31:16], mask_hi);
    assign eq_lo_d = half_eq(lfsr_i[15:0], match_i[15:0], mask_lo);
    // A sample is only valid if the timer is running now and keeps running.
    assign v1_d    = run_i & ~flush_i;
    assign hit_d   = v1_q & eq_hi_q & eq_lo_q & run_i & ~flush_i;

    assign hit_o     = hit_q;
    assign hit_set_o = hit_d;

    // Pipeline registers; leaving RUN clears valid and hit on the same edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            eq_hi_q <= 1'b0;
            eq_lo_q <= 1'b0;
            v1_q    <= 1'b0;
            hit_q   <= 1'b0;
        end else begin
            eq_hi_q <= eq_hi_d;
            eq_lo_q <= eq_lo_d;
            v1_q    <= v1_d;
            hit_q   <= hit_d;
        end
    end

endmodule

// File: rtl/lfsr_match_timer.sv
// Controller for a 32-bit LFSR counter: clears it, runs it, ticks on a pattern match.
// Define LFSR_MATCH_MASK_EN to add the match_mask don't-care input.
module lfsr_match_timer
    import lfsr_pkg::*;
#(
    parameter logic [31:0] MATCH_DEFAULT = MATCH_PATTERN,
    parameter int          AUTO_RELOAD   = 1,
    parameter int          CNT_W         = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             stop,
    input  logic             match_sel,
    input  logic [31:0]      match_value,
`ifdef LFSR_MATCH_MASK_EN
    input  logic [31:0]      match_mask,
`endif
    input  logic [31:0]      lfsr_in,
    output logic             lfsr_ce,
    output logic             lfsr_clr,
    output logic             tick,
    output logic             busy,
    output logic [CNT_W-1:0] match_count
);

    state_e            state_q, state_d;
    logic [31:0]       match_q, match_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              ce_q, clr_q, busy_q;
    logic              hit_q, hit_set, accept_start;
`ifdef LFSR_MATCH_MASK_EN
    logic [31:0]       mask_q, mask_d;
`endif

    assign accept_start = (state_q == IDLE) & start & ~stop;

    // Next state: stop overrides everything, a stage-2 hit ends the run.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = CLEAR;
            CLEAR:   state_d = RUN;
            RUN: begin
                if (hit_q) begin
                    if (AUTO_RELOAD != 0) state_d = CLEAR;
                    else                  state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (stop) state_d = IDLE;
    end

    // Pattern latch and saturating match counter.
    always_comb begin
        match_d = match_q;
        cnt_d   = cnt_q;
`ifdef LFSR_MATCH_MASK_EN
        mask_d  = mask_q;
`endif
        if (accept_start) begin
            match_d = match_sel ? match_value : MATCH_DEFAULT;
`ifdef LFSR_MATCH_MASK_EN
            mask_d  = match_mask;
`endif
            cnt_d   = '0;
        end else if (hit_set && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    lfsr_match_cmp u_cmp (
        .clk       (clk),
        .reset_n   (reset_n),
        .lfsr_i    (lfsr_in),
        .match_i   (match_q),
`ifdef LFSR_MATCH_MASK_EN
        .mask_i    (mask_q),
`endif
        .run_i     (state_q == RUN),
        .flush_i   (state_d != RUN),
        .hit_o     (hit_q),
        .hit_set_o (hit_set)
    );

    // State, latched pattern, counter and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            match_q <= 32'h0;
`ifdef LFSR_MATCH_MASK_EN
            mask_q  <= 32'h0;
`endif
            cnt_q   <= '0;
            ce_q    <= 1'b0;
            clr_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            match_q <= match_d;
`ifdef LFSR_MATCH_MASK_EN
            mask_q  <= mask_d;
`endif
            cnt_q   <= cnt_d;
            ce_q    <= (state_d == RUN);
            clr_q   <= (state_d == CLEAR);
            busy_q  <= (state_d != IDLE);
        end
    end

    assign lfsr_ce     = ce_q;
    assign lfsr_clr    = clr_q;
    assign busy        = busy_q;
    assign tick        = hit_q;
    assign match_count = cnt_q;

endmodule

// File: tb/tb_lfsr_match_timer.sv
// Bench for lfsr_match_timer: two instances (auto-reload 2-bit counter, one-shot 16-bit).
// Behavioural timeline model checked every cycle plus directed literal checks.
module tb_lfsr_match_timer;

    localparam logic [31:0] P = 32'h81234567;
    localparam int IDL = 0, CLR = 1, RN = 2;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0, stop = 1'b0, match_sel = 1'b0;
    logic [31:0] match_value = 32'h0, lfsr_in = 32'h0;
    logic [31:0] match_mask = 32'h0;
    logic        a_ce, a_clr, a_tick, a_busy;
    logic        b_ce, b_clr, b_tick, b_busy;
    logic [1:0]  a_cnt;
    logic [15:0] b_cnt;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    lfsr_match_timer #(.AUTO_RELOAD(1), .CNT_W(2)) u_a (
        .clk(clk), .reset_n(reset_n), .start(start), .stop(stop),
        .match_sel(match_sel), .match_value(match_value),
`ifdef LFSR_MATCH_MASK_EN
        .match_mask(match_mask),
`endif
        .lfsr_in(lfsr_in), .lfsr_ce(a_ce), .lfsr_clr(a_clr),
        .tick(a_tick), .busy(a_busy), .match_count(a_cnt)
    );

    lfsr_match_timer #(.AUTO_RELOAD(0), .CNT_W(16)) u_b (
        .clk(clk), .reset_n(reset_n), .start(start), .stop(stop),
        .match_sel(match_sel), .match_value(match_value),
`ifdef LFSR_MATCH_MASK_EN
        .match_mask(match_mask),
`endif
        .lfsr_in(lfsr_in), .lfsr_ce(b_ce), .lfsr_clr(b_clr),
        .tick(b_tick), .busy(b_busy), .match_count(b_cnt)
    );

    // ---------------- model ----------------
    // Each instance has a phase per cycle; a sample at cycle n ticks at n+2
    // only if the instance is running in all of n, n+1 and n+2.
    int          ph0[2] = '{IDL, IDL};
    int          ph1[2] = '{IDL, IDL};
    bit          tk[2]  = '{1'b0, 1'b0};
    int          cnt[2] = '{0, 0};
    logic [31:0] pat[2] = '{32'h0, 32'h0};
    logic [31:0] msk[2] = '{32'h0, 32'h0};
    logic [31:0] lf1 = 32'h0;
    int          ar[2]   = '{1, 0};
    int          maxc[2] = '{3, 65535};

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            ph0[d] = IDL; ph1[d] = IDL; tk[d] = 1'b0;
            cnt[d] = 0; pat[d] = 32'h0; msk[d] = 32'h0;
        end
        lf1 = 32'h0;
    endtask

    task automatic model_step(int d);
        int nxt;
        bit ntk;
        bit acc;
        acc = (ph0[d] == IDL) && start && !stop;
        if (stop) nxt = IDL;
        else if (ph0[d] == IDL) nxt = start ? CLR : IDL;
        else if (ph0[d] == CLR) nxt = RN;
        else if (tk[d]) nxt = (ar[d] != 0) ? CLR : IDL;
        else nxt = RN;
        ntk = (ph1[d] == RN) && (ph0[d] == RN) && (nxt == RN)
              && (((lf1 ^ pat[d]) & ~msk[d]) == 32'h0);
        if (acc) cnt[d] = 0;
        else if (ntk && cnt[d] < maxc[d]) cnt[d] = cnt[d] + 1;
        if (acc) begin
            pat[d] = match_sel ? match_value : P;
`ifdef LFSR_MATCH_MASK_EN
            msk[d] = match_mask;
`else
            msk[d] = 32'h0;
`endif
        end
        ph1[d] = ph0[d];
        ph0[d] = nxt;
        tk[d]  = ntk;
    endtask

    initial forever begin
        @(posedge clk or negedge reset_n);
        if (!reset_n) model_reset();
        else begin
            model_step(0);
            model_step(1);
            lf1 = lfsr_in;
        end
    end

    // ---------------- checking ----------------
    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic cmp(int d, logic ce, logic clr, logic t, logic bz, logic [31:0] c);
        logic [31:0] act, exp;
        act = {24'h0, 3'b0, ce, clr, t, bz, 1'b0};
        exp = {24'h0, 3'b0, 1'(ph0[d] == RN), 1'(ph0[d] == CLR), tk[d],
               1'(ph0[d] != IDL), 1'b0};
        chk(d == 0 ? "model_a_flags" : "model_b_flags", act, exp);
        chk(d == 0 ? "model_a_count" : "model_b_count", c, 32'(cnt[d]));
    endtask

    initial forever begin
        @(negedge clk);
        cmp(0, a_ce, a_clr, a_tick, a_busy, 32'(a_cnt));
        cmp(1, b_ce, b_clr, b_tick, b_busy, 32'(b_cnt));
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    // ---------------- directed stimulus ----------------
    initial begin
        repeat (3) cyc();
        smp();
        chk("rst_a", {27'h0, a_ce, a_clr, a_tick, a_busy, |a_cnt}, 32'h0);
        chk("rst_b", {27'h0, b_ce, b_clr, b_tick, b_busy, |b_cnt}, 32'h0);
        cyc();
        reset_n = 1'b1;
        cyc();
        start = 1'b1;
        cyc();
        start = 1'b0;
        smp();
        chk("clr_pulse", 32'(a_clr), 32'h1);
        chk("clear_ce", 32'(a_ce), 32'h0);
        cyc();
        lfsr_in = P;
        smp();
        chk("run_ce", 32'(a_ce), 32'h1);
        chk("run_busy", 32'(b_busy), 32'h1);
        cyc();
        lfsr_in = 32'h0;
        smp();
        chk("tick_early", 32'(a_tick), 32'h0);
        cyc();
        smp();
        chk("tick_t2_a", 32'(a_tick), 32'h1);
        chk("tick_t2_b", 32'(b_tick), 32'h1);
        chk("cnt_t2", 32'(a_cnt), 32'h1);
        cyc();
        smp();
        chk("clr_t3", 32'(a_clr), 32'h1);
        chk("oneshot_idle", 32'(b_busy), 32'h0);
        chk("tick_pulse", 32'(a_tick), 32'h0);

        start = 1'b1;
        cyc();
        start = 1'b0;
        cyc();
        lfsr_in = 32'h81230000;
        cyc();
        lfsr_in = 32'h00004567;
        cyc();
        lfsr_in = 32'h0;
        cyc();
        smp();
        chk("half_tick", 32'(a_tick), 32'h0);
        chk("half_cnt", 32'(a_cnt), 32'h1);

        stop = 1'b1;
        cyc();
        stop = 1'b0;
        match_sel = 1'b1;
        match_value = 32'hDEADBEEF;
        start = 1'b1;
        cyc();
        start = 1'b0;
        match_sel = 1'b0;
        match_value = 32'h0;
        cyc();
        lfsr_in = P;
        cyc();
        lfsr_in = 32'hDEADBEEF;
        cyc();
        lfsr_in = 32'h0;
        smp();
        chk("no_dflt", 32'(a_tick), 32'h0);
        cyc();
        smp();
        chk("prog_hit_a", 32'(a_tick), 32'h1);
        chk("prog_hit_b", 32'(b_tick), 32'h1);
        chk("prog_cnt", 32'(a_cnt), 32'h1);

        stop = 1'b1;
        cyc();
        stop = 1'b0;
        start = 1'b1;
        cyc();
        start = 1'b0;
        cyc();
        lfsr_in = P;
        cyc();
        lfsr_in = 32'h0;
        cyc();
        smp();
        chk("reload_cnt", 32'(a_cnt), 32'h1);
        cyc();
        cyc();
        lfsr_in = P;
        cyc();
        lfsr_in = 32'h0;
        stop = 1'b1;
        cyc();
        stop = 1'b0;
        smp();
        chk("stop_tick", 32'(a_tick), 32'h0);
        chk("stop_idle", 32'(a_busy), 32'h0);
        chk("stop_hold", 32'(a_cnt), 32'h1);
        cyc();
        start = 1'b1;
        stop = 1'b1;
        cyc();
        start = 1'b0;
        stop = 1'b0;
        smp();
        chk("startstop_busy", 32'(a_busy), 32'h0);
        chk("startstop_clr", 32'(b_clr), 32'h0);

        start = 1'b1;
        cyc();
        start = 1'b0;
        lfsr_in = P;
        repeat (30) cyc();
        smp();
        chk("sat_cnt", 32'(a_cnt), 32'h3);
        chk("oneshot_cnt", 32'(b_cnt), 32'h1);
        chk("oneshot_done", 32'(b_busy), 32'h0);

        @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_rst_a", {27'h0, a_ce, a_clr, a_tick, a_busy, |a_cnt}, 32'h0);
        chk("async_rst_b", {27'h0, b_ce, b_clr, b_tick, b_busy, |b_cnt}, 32'h0);
        cyc();
        cyc();
        reset_n = 1'b1;
        repeat (4) cyc();
        smp();
        chk("no_tick_rel", {30'h0, a_tick, a_busy}, 32'h0);

        match_mask = 32'h0000FFFF;
        start = 1'b1;
        cyc();
        start = 1'b0;
        lfsr_in = 32'h0;
        cyc();
        lfsr_in = 32'h8123ABCD;
        cyc();
        lfsr_in = 32'h0;
        cyc();
        smp();
`ifdef LFSR_MATCH_MASK_EN
        chk("mask_hit", 32'(a_tick), 32'h1);
`else
        chk("exact_miss", 32'(a_tick), 32'h0);
`endif
        repeat (3) cyc();
        smp();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lfsr_match_timer.md
Name: lfsr_match_timer

Overview:
- Downstream controller for the 32-bit LFSR counter (Galois-free Fibonacci, XNOR taps 31/21/1/0, resets to 0).
- Drives the counter's count-enable and clear. Consumes its state word and detects a 32-bit match pattern with a 2-stage split compare (2x16 bits, for timing).
- Emits a one-cycle tick per match, counts matches, and restarts the LFSR, either periodically or one-shot.

Parameters:
- MATCH_DEFAULT, 32'h81234567, match value used when `match_sel` = 0.
- AUTO_RELOAD, 1, 1: restart after each match; 0: stop after first match.
- CNT_W, 16, width of the saturating match counter.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- start  in  1  1-cycle request to begin timing
- stop  in  1  1-cycle request to abort, return to IDLE
- match_sel  in  1  0: use MATCH_DEFAULT; 1: use match_value
- match_value  in  32  programmable match pattern
- lfsr_in  in  32  current LFSR counter state
- lfsr_ce  out  1  count enable to LFSR counter
- lfsr_clr  out  1  registered clear pulse to LFSR counter reset input
- tick  out  1  one-cycle pulse on match
- busy  out  1  high in CLEAR or RUN
- match_count  out  CNT_W  saturating number of matches since start

Behaviour:
- Clock and reset: one clock, `clk`. Reset is `reset_n`, asynchronous, active-low.
- Reset values: state = IDLE; `lfsr_ce`, `lfsr_clr`, `tick`, `busy` = 0; `match_count` = 0; all pipeline registers and valid bits = 0; latched match = 0.
- Match latching: on accepted `start`, the effective match value is latched (`match_sel` ? `match_value` : MATCH_DEFAULT). Changes to `match_sel` or `match_value` mid-run are ignored.
- States: IDLE, CLEAR, RUN. All outputs are registered.
- IDLE:
  - `start` -> CLEAR.
  - `match_count` is cleared on accepted `start`.
- CLEAR (exactly 1 cycle):
  - `lfsr_clr` = 1, `lfsr_ce` = 0, `busy` = 1.
  - Next state: RUN.
- RUN:
  - `lfsr_ce` = 1, `busy` = 1.
  - On a stage-2 match:
    - `tick` = 1 next cycle.
    - `match_count` += 1, saturating at all-ones.
    - Next state: CLEAR if AUTO_RELOAD = 1, else IDLE.
- Compare pipeline:
  - Stage 1 registers `eq_hi` = (`lfsr_in[31:16]` == match[31:16]) and `eq_lo` = (`lfsr_in[15:0]` == match[15:0]). `v1` = (state == RUN).
  - Stage 2 registers `hit` = `v1` & `eq_hi` & `eq_lo` & (state == RUN).
  - Latency: `lfsr_in` value -> `tick` = 2 cycles.
  - Values presented while not in RUN never produce `tick`.
- Flush: on leaving RUN (match, stop, or reset), `v1` and `hit` are forced to 0 the same edge. No stale hit may fire after CLEAR or in IDLE.
- Stop:
  - `stop` in any state -> IDLE next edge; `lfsr_ce` = 0, `lfsr_clr` = 0, `busy` = 0, pipeline flushed.
  - `match_count` is held, not cleared.
- Priority, same cycle: `stop` > `hit` > `start`.
  - `start` outside IDLE is ignored.
  - `hit` coincident with `stop`: no `tick`, no count.
- Period with AUTO_RELOAD = 1: N LFSR steps to match + 2 pipeline cycles + 1 CLEAR cycle. The overshoot steps are discarded by the clear.
- Reset mid-operation: immediate return to reset values; no `tick` on release.

Optional Feature:
- Macro LFSR_MATCH_MASK_EN.
- Defined:
  - Adds input `match_mask` [31:0]. A 1 bit means "don't care".
  - Mask is latched with the match value on `start`.
  - Stage 1 compares `(lfsr_in ^ match) & ~mask` == 0 per half.
- Undefined: no `match_mask` port; exact 32-bit compare.

Decomposition:
- Shared package `lfsr_pkg`:
  - State encoding constants (IDLE = 2'd0, CLEAR = 2'd1, RUN = 2'd2).
  - `LFSR_W` = 32.
  - `MATCH_PATTERN` = 32'h81234567.
  - `MATCH_PATTERN_PRESCALE` = 16'h8123.
- Sub-module `lfsr_match_cmp`: 2-stage split comparator (halves, valid, flush, optional mask). The FSM and counter stay in the top.

Test Plan:
1. Reset -> all outputs 0 while `reset_n` = 0. Pulse `start`, `match_sel` = 0 -> `lfsr_clr` = 1 for 1 cycle, then `lfsr_ce` = 1, `busy` = 1.
2. In RUN, drive `lfsr_in` = 32'h81234567 for one cycle at cycle T -> `tick` = 1 exactly at T+2, `match_count` = 1, `lfsr_clr` = 1 at T+3 (AUTO_RELOAD = 1).
3. Drive 32'h81230000 then 32'h00004567 -> no `tick` (half matches only). With `match_sel` = 1 and `match_value` = 32'hDEADBEEF latched, 32'h81234567 -> no `tick`, 32'hDEADBEEF -> `tick`.
4. Matching value at T, `stop` at T+1 -> no `tick`, IDLE, `match_count` unchanged. `start` and `stop` together in IDLE -> stays IDLE.
5. AUTO_RELOAD = 0, CNT_W = 2: one match -> IDLE, `busy` = 0. Restart and hit 5 times with AUTO_RELOAD = 1 -> `match_count` saturates at 3.
6. With LFSR_MATCH_MASK_EN, mask = 32'h0000FFFF, match 32'h81234567 -> `lfsr_in` 32'h8123ABCD produces `tick`; `reset_n` low mid-RUN -> all outputs 0 immediately.
